// File: rtl/sim_mem_burst_model.sv
// Multi-channel burst-read memory model: one shared storage array, one write port,
// NUM_CH independent read channels with a fixed RD_LAT-cycle return pipeline.
module sim_mem_burst_model #(
    parameter int DATA_W  = 128,
    parameter int ADDR_W  = 16,
    parameter int DEPTH   = 32,
    parameter int NUM_CH  = 3,
    parameter int RD_LAT  = 1,
    parameter int LEN_W   = 8,
    parameter int WR_MODE = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [NUM_CH-1:0]          rd_req,
    input  logic [NUM_CH*ADDR_W-1:0]   rd_addr,
    input  logic [NUM_CH*LEN_W-1:0]    rd_len,
    output logic [NUM_CH-1:0]          rd_busy,
    output logic [NUM_CH*DATA_W-1:0]   rd_data,
    output logic [NUM_CH-1:0]          rd_valid,
    output logic [NUM_CH-1:0]          rd_last,
    output logic [NUM_CH-1:0]          rd_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_hit;

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + ADDR_W'(1);
    endfunction

    assign wr_hit = wr_en && ({1'b0, wr_addr} < DEPTH_L);

    // Storage is deliberately not reset so preloaded contents survive a reset.
    always_ff @(posedge clk) begin
        if (wr_hit) begin
            mem[wr_addr[IDX_W-1:0]] <= wr_data;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [0:0]        state_q, state_d;
        logic [ADDR_W-1:0] addr_q, addr_d;
        logic [LEN_W-1:0]  remain_q, remain_d;
        logic              err_q, err_d;
        logic              issue, issue_last;
        logic [ADDR_W-1:0] issue_addr;
        logic [ADDR_W-1:0] req_addr;
        logic [LEN_W-1:0]  req_len;
        logic              req_in_range;
        logic [DATA_W-1:0] beat_data;

        logic              pipe_vld_q  [RD_LAT];
        logic              pipe_vld_d  [RD_LAT];
        logic              pipe_last_q [RD_LAT];
        logic              pipe_last_d [RD_LAT];
        logic [DATA_W-1:0] pipe_data_q [RD_LAT];
        logic [DATA_W-1:0] pipe_data_d [RD_LAT];

        assign req_addr     = rd_addr[c*ADDR_W +: ADDR_W];
        assign req_len      = rd_len[c*LEN_W +: LEN_W];
        assign req_in_range = ({1'b0, req_addr} < DEPTH_L);

        // The address check outranks the zero-length check, so a bad address always errors.
        always_comb begin
            state_d    = state_q;
            addr_d     = addr_q;
            remain_d   = remain_q;
            err_d      = 1'b0;
            issue      = 1'b0;
            issue_last = 1'b0;
            issue_addr = addr_q;
            case (state_q)
                ST_IDLE: begin
                    if (rd_req[c]) begin
                        if (!req_in_range) begin
                            err_d = 1'b1;
                        end else if (req_len != '0) begin
                            issue      = 1'b1;
                            issue_addr = req_addr;
                            issue_last = (req_len == LEN_W'(1));
                            if (!issue_last) begin
                                state_d  = ST_BURST;
                                remain_d = req_len - LEN_W'(1);
                                addr_d   = next_addr(req_addr);
                            end
                        end
                    end
                end
                default: begin
                    issue      = 1'b1;
                    issue_addr = addr_q;
                    issue_last = (remain_q == LEN_W'(1));
                    remain_d   = remain_q - LEN_W'(1);
                    addr_d     = next_addr(addr_q);
                    if (issue_last) begin
                        state_d = ST_IDLE;
                    end
                end
            endcase
        end

        always_comb begin
            if ((WR_MODE == 1) && wr_hit && (wr_addr == issue_addr)) begin
                beat_data = wr_data;
            end else begin
                beat_data = mem[issue_addr[IDX_W-1:0]];
            end
        end

        // Stage 0 holds the beat issued this cycle; data is zeroed whenever the beat is absent.
        always_comb begin
            pipe_vld_d[0]  = issue;
            pipe_last_d[0] = issue && issue_last;
            pipe_data_d[0] = issue ? beat_data : '0;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld_d[i]  = pipe_vld_q[i-1];
                pipe_last_d[i] = pipe_last_q[i-1];
                pipe_data_d[i] = pipe_data_q[i-1];
            end
        end

        always_ff @(posedge clk) begin
            if (!rst) begin
                state_q  <= ST_IDLE;
                addr_q   <= '0;
                remain_q <= '0;
                err_q    <= 1'b0;
                for (int i = 0; i < RD_LAT; i++) begin
                    pipe_vld_q[i]  <= 1'b0;
                    pipe_last_q[i] <= 1'b0;
                    pipe_data_q[i] <= '0;
                end
            end else begin
                state_q  <= state_d;
                addr_q   <= addr_d;
                remain_q <= remain_d;
                err_q    <= err_d;
                for (int i = 0; i < RD_LAT; i++) begin
                    pipe_vld_q[i]  <= pipe_vld_d[i];
                    pipe_last_q[i] <= pipe_last_d[i];
                    pipe_data_q[i] <= pipe_data_d[i];
                end
            end
        end

        assign rd_busy[c]                   = (state_q == ST_BURST);
        assign rd_valid[c]                  = pipe_vld_q[RD_LAT-1];
        assign rd_last[c]                   = pipe_last_q[RD_LAT-1];
        assign rd_data[c*DATA_W +: DATA_W]  = pipe_data_q[RD_LAT-1];
        assign rd_err[c]                    = err_q;
    end

endmodule

// File: doc/sim_mem_burst_model.md
Name: sim_mem_burst_model

Overview:
Parametrised, synthesisable multi-channel memory model for the accelerator bench. It replaces the combinational per-array lookups for feature, weight and instruction storage. One shared storage array serves NUM_CH independent read channels. Each channel performs burst reads with a configurable read latency and returns data with valid/last qualifiers. A single write port is used for preload and for runtime writes.

Parameters:
DATA_W, 128, word width in bits
ADDR_W, 16, address width of every port
DEPTH, 32, number of words in storage (DEPTH <= 2^ADDR_W)
NUM_CH, 3, number of independent read channels
RD_LAT, 1, cycles from beat issue to rd_valid; legal range 1..4
LEN_W, 8, width of the burst length field
WR_MODE, 0, read/write collision policy: 0 = read-first (old data), 1 = write-first (new data)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous reset, active-low
wr_en  in  1  write strobe
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
rd_req  in  NUM_CH  per-channel burst request, one bit per channel
rd_addr  in  NUM_CH*ADDR_W  per-channel start address, channel c at slice [c*ADDR_W +: ADDR_W]
rd_len  in  NUM_CH*LEN_W  per-channel burst length in beats
rd_busy  out  NUM_CH  channel is in BURST state
rd_data  out  NUM_CH*DATA_W  per-channel read data
rd_valid  out  NUM_CH  rd_data qualifier
rd_last  out  NUM_CH  marks the final beat of a burst
rd_err  out  NUM_CH  one-cycle pulse when a request is rejected for an out-of-range address

Behaviour:
- Reset (rst==0 at a clock edge):
  - all channel FSMs go to IDLE; latency pipelines are flushed.
  - rd_busy, rd_valid, rd_last and rd_err all reset to 0; rd_data resets to 0.
  - storage contents are NOT cleared.
- Per-channel FSM, states IDLE and BURST:
  - IDLE with rd_req[c]=1, rd_len[c]!=0 and rd_addr[c]<DEPTH: accept the request. The first beat is issued in the accept cycle. If rd_len==1, stay in IDLE. Otherwise go to BURST with remaining = rd_len-1 and the next address latched.
  - IDLE with rd_req[c]=1 and rd_len[c]==0: the request is ignored. No beats, no error.
  - IDLE with rd_req[c]=1 and rd_addr[c]>=DEPTH: the request is rejected. rd_err[c]=1 in the next cycle only; no beats issued. The address check takes priority over the len==0 check.
  - BURST: issue one beat per cycle. Decrement remaining. Go to IDLE in the cycle the final beat is issued.
  - rd_busy[c]=1 exactly while in BURST. rd_req[c] is ignored while rd_busy[c]=1.
- Back-to-back bursts: a request presented in the cycle after the final beat issues is accepted. The minimum gap between bursts is therefore 0 idle issue cycles after IDLE is reached.
- Address arithmetic: the beat address increments by 1 and wraps from DEPTH-1 to 0. Bursts longer than DEPTH re-read words. The maximum burst length is 2^LEN_W-1.
- Latency: a beat issued at cycle t drives rd_data/rd_valid at cycle t+RD_LAT. rd_last accompanies the final beat.
- rd_data is 0 whenever rd_valid is 0. Bursts produce contiguous valid beats with no bubbles. There is no backpressure.
- Channels are fully independent. Any number of channels may read the same address in the same cycle.
- Writes: when wr_en=1 and wr_addr<DEPTH, the word is written at the clock edge. A write to an address >=DEPTH is dropped silently.
- Read/write collision: when a beat reads an address written in the same cycle, rd_data carries the old word if WR_MODE=0 and wr_data if WR_MODE=1.
- Reset asserted mid-burst: the burst is aborted and in-flight beats are discarded. rd_valid is 0 from the first cycle after the reset edge.
- Storage is initialisable from the bench by $readmemh on the internal array (hierarchical path mem).

Test Plan:
- Preload via wr_en, mem[i]=i+1 for i=0..31; ch0 request addr=4, len=4, RD_LAT=1 -> rd_valid high for 4 consecutive cycles starting 1 cycle after request; data 5,6,7,8; rd_last on the 4th beat; rd_busy high for 3 cycles.
- Wrap test: ch1 addr=30, len=4 -> data 31,32,1,2.
- Latency sweep: RD_LAT=3, ch2 addr=0, len=2 -> first valid 3 cycles after request, data 1,2. Channels 0/1/2 requesting addr 10 simultaneously -> all three return 11 in the same cycle.
- Boundary: addr=32 -> rd_err pulse 1 cycle, no valid. len=0 -> nothing happens. rd_req while busy -> ignored; the burst completes unchanged.
- Collision: mem[5]=6, then wr_en addr=5 data=0xAA in the same cycle as the beat issue to addr 5 -> returns 6 (WR_MODE=0) or 0xAA (WR_MODE=1).
- Reset mid-burst: len=8, drive rst=0 after beat 3 issues -> rd_valid and rd_busy are 0 the next cycle. After release, a new request addr=0, len=1 returns 1.
